// File: rtl/regbank_pkg.sv
// Shared types and default sizing for the register bank.
package regbank_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/regbank_read_port.sv
// One registered read port: entry select, optional write-through, zero forcing.
// Write-through of a same-edge write is enabled by defining REGFILE_BYPASS_EN.
module regbank_read_port
   import regbank_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int ZERO_R0 = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    entries,
   input  logic [ADDR_W-1:0]                     addr,
   input  logic                                  clear,
   input  logic                                  we,
   input  logic [ADDR_W-1:0]                     wr_addr,
   input  logic [DATA_W-1:0]                     wr_data,
   output logic [DATA_W-1:0]                     rdata
);

   logic [DATA_W-1:0] rd_d;

`ifndef REGFILE_BYPASS_EN
   // Write-side inputs only matter when forwarding is built in.
   logic unused_byp;
   assign unused_byp = ^{we, wr_addr, wr_data};
`endif

   always_comb begin
      rd_d = entries[addr];
`ifdef REGFILE_BYPASS_EN
      // we is already gated to ST_IDLE and excludes a suppressed entry 0.
      if (we && (wr_addr == addr))
         rd_d = wr_data;
`endif
      if (clear || ((ZERO_R0 != 0) && (addr == '0)))
         rd_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata <= '0;
      else     rdata <= rd_d;
   end

endmodule

// File: rtl/reg_bank_param.sv
// Register bank, 2**ADDR_W x DATA_W, one write / two registered reads, with a
// clear sweep after reset or init_req. Optional macro: REGFILE_BYPASS_EN.
module reg_bank_param
   import regbank_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int ZERO_R0 = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write,
   input  logic [ADDR_W-1:0] dr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] sr1,
   input  logic [ADDR_W-1:0] sr2,
   input  logic              init_req,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   output logic              busy
);

   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   state_t                       state_q, state_d;
   logic [ADDR_W-1:0]            cnt_q, cnt_d;
   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic                         we;

   assign busy = (state_q == ST_CLEAR);
   assign we   = (state_q == ST_IDLE) && write && !((ZERO_R0 != 0) && (dr == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            // Terminal count checked before the counter wraps.
            if (cnt_q == LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
      endcase
   end

   // Storage has no reset; the sweep is what initialises it.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) mem[cnt_q] <= '0;
      else if (we)             mem[dr]    <= write_data;
   end

   logic [1:0][ADDR_W-1:0] rd_addr;
   logic [1:0][DATA_W-1:0] rd_data;

   assign rd_addr     = {sr2, sr1};
   assign read_data_1 = rd_data[0];
   assign read_data_2 = rd_data[1];

   for (genvar p = 0; p < 2; p++) begin : g_rd
      regbank_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_R0 (ZERO_R0)
      ) u_port (
         .clk     (clk),
         .rst     (rst),
         .entries (mem),
         .addr    (rd_addr[p]),
         .clear   (busy),
         .we      (we),
         .wr_addr (dr),
         .wr_data (write_data),
         .rdata   (rd_data[p])
      );
   end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed vector bench for reg_bank_param (DEPTH=4), ZERO_R0=0 and ZERO_R0=1 instances.
module tb_reg_bank_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write = 1'b0;
   logic [1:0]  dr = '0;
   logic [31:0] write_data = '0;
   logic [1:0]  sr1 = '0;
   logic [1:0]  sr2 = '0;
   logic        init_req = 1'b0;
   logic [31:0] read_data_1, read_data_2, z_rd1, z_rd2;
   logic        busy, z_busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_bank_param #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(0)) u_dut (
      .clk(clk), .rst(rst), .write(write), .dr(dr), .write_data(write_data),
      .sr1(sr1), .sr2(sr2), .init_req(init_req),
      .read_data_1(read_data_1), .read_data_2(read_data_2), .busy(busy)
   );

   reg_bank_param #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(1)) u_dut_z (
      .clk(clk), .rst(rst), .write(write), .dr(dr), .write_data(write_data),
      .sr1(sr1), .sr2(sr2), .init_req(init_req),
      .read_data_1(z_rd1), .read_data_2(z_rd2), .busy(z_busy)
   );

   typedef struct {
      logic        wr;
      logic [1:0]  d;
      logic [31:0] wd;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic        ini;
      logic [31:0] e1;
      logic [31:0] e2;
      logic        eb;
   } vec_t;

   function automatic vec_t mk(logic wr, logic [1:0] d, logic [31:0] wd, logic [1:0] s1,
                               logic [1:0] s2, logic ini, logic [31:0] e1, logic [31:0] e2,
                               logic eb);
      vec_t v;
      v.wr = wr; v.d = d; v.wd = wd; v.s1 = s1; v.s2 = s2; v.ini = ini;
      v.e1 = e1; v.e2 = e2; v.eb = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [1:0] d, input logic [31:0] wd,
                        input logic [1:0] s1, input logic [1:0] s2, input logic ini);
      write = wr; dr = d; write_data = wd; sr1 = s1; sr2 = s2; init_req = ini;
   endtask

   vec_t tv[19];

   initial begin
      // Post-sweep sequence; each row's expectation is the state after its edge.
      tv[0]  = mk(0, 0, 32'h0,        0, 1, 0, 32'h0, 32'h0, 0);
      tv[1]  = mk(0, 0, 32'h0,        2, 3, 0, 32'h0, 32'h0, 0);
      tv[2]  = mk(1, 2, 32'hDEADBEEF, 3, 3, 0, 32'h0, 32'h0, 0);
      tv[3]  = mk(0, 0, 32'h0,        2, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
      tv[4]  = mk(1, 1, 32'hAAAA0000, 2, 0, 0, 32'hDEADBEEF, 32'h0, 0);
      tv[5]  = mk(1, 1, 32'h12345678, 1, 2, 0, BYP ? 32'h12345678 : 32'hAAAA0000, 32'hDEADBEEF, 0);
      tv[6]  = mk(0, 0, 32'h0,        1, 1, 0, 32'h12345678, 32'h12345678, 0);
      tv[7]  = mk(1, 0, 32'h11,       3, 1, 0, 32'h0, 32'h12345678, 0);
      tv[8]  = mk(1, 1, 32'h22,       0, 2, 0, 32'h11, 32'hDEADBEEF, 0);
      tv[9]  = mk(1, 2, 32'h33,       1, 0, 0, 32'h22, 32'h11, 0);
      tv[10] = mk(1, 3, 32'h44,       2, 3, 0, 32'h33, BYP ? 32'h44 : 32'h0, 0);
      tv[11] = mk(0, 0, 32'h0,        3, 0, 0, 32'h44, 32'h11, 0);
      // init_req with a same-edge write: the write commits, sweep starts.
      tv[12] = mk(1, 0, 32'h99,       0, 1, 1, BYP ? 32'h99 : 32'h11, 32'h22, 1);
      tv[13] = mk(1, 0, 32'h55,       0, 1, 1, 32'h0, 32'h0, 1);
      tv[14] = mk(1, 1, 32'h55,       2, 3, 1, 32'h0, 32'h0, 1);
      tv[15] = mk(1, 2, 32'h55,       0, 1, 1, 32'h0, 32'h0, 1);
      tv[16] = mk(0, 0, 32'h0,        0, 1, 1, 32'h0, 32'h0, 0);
      tv[17] = mk(0, 0, 32'h0,        0, 1, 0, 32'h0, 32'h0, 0);
      tv[18] = mk(0, 0, 32'h0,        2, 3, 0, 32'h0, 32'h0, 0);

      // Reset state.
      step();
      chk("rst_rd1", read_data_1, 32'h0);
      chk("rst_rd2", read_data_2, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h1);
      chk("rst_z_busy", {31'h0, z_busy}, 32'h1);
      rst = 1'b0;

      // Initial sweep: busy for exactly four edges.
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("sweep_busy_e%0d", i), {31'h0, busy}, (i < 4) ? 32'h1 : 32'h0);
      end

      foreach (tv[i]) begin
         drive(tv[i].wr, tv[i].d, tv[i].wd, tv[i].s1, tv[i].s2, tv[i].ini);
         step();
         chk($sformatf("v%0d_rd1", i), read_data_1, tv[i].e1);
         chk($sformatf("v%0d_rd2", i), read_data_2, tv[i].e2);
         chk($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, tv[i].eb});
      end

      // ZERO_R0: entry 0 ignores writes and reads 0.
      drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      step();
      chk("z_wr0_rd1", z_rd1, 32'h0);
      chk("n_wr0_rd1", read_data_1, BYP ? 32'hFFFFFFFF : 32'h0);
      drive(1, 1, 32'h77, 0, 1, 0);
      step();
      chk("z_rd0", z_rd1, 32'h0);
      chk("n_rd0", read_data_1, 32'hFFFFFFFF);
      drive(0, 0, 32'h0, 1, 0, 0);
      step();
      chk("z_rd1_e1", z_rd1, 32'h77);
      chk("z_rd2_e0", z_rd2, 32'h0);

      // Reset mid-sweep at counter 2 restarts a full sweep.
      drive(0, 0, 32'h0, 0, 0, 1);
      step();
      chk("ms_busy0", {31'h0, busy}, 32'h1);
      init_req = 1'b0;
      step();
      step();
      rst = 1'b1;
      #1;
      chk("ms_rst_busy", {31'h0, busy}, 32'h1);
      chk("ms_rst_rd1", read_data_1, 32'h0);
      step();
      step();
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk($sformatf("ms_busy_e%0d", i), {31'h0, busy}, (i < 4) ? 32'h1 : 32'h0);
         chk($sformatf("ms_z_busy_e%0d", i), {31'h0, z_busy}, (i < 4) ? 32'h1 : 32'h0);
      end
      drive(0, 0, 32'h0, 1, 2, 0);
      step();
      chk("ms_rd1_cleared", read_data_1, 32'h0);
      chk("ms_rd2_cleared", read_data_2, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
